mips_regfile_write_arbiter: RTL and testbench
=============================================

// Module: mips_regfile_write_arbiter
// PURPOSE
//  Single owner of the mips_registers write port (write_reg / write_data / signal_reg_write).
//  Zero-fills all registers after reset, then shares the port between two requesters.
//  Requester 0 is ALU writeback; requester 1 is load/memory return.
//  Round-robin arbitration, valid/ready handshake, one registered write per cycle.
// PARAMETERS
//  NREGS           32  number of architectural registers swept by the clear sequence
//  ADDR_W          5   register index width
//  DATA_W          32  register data width
//  CLEAR_ON_RESET  1   1: run the zero-fill sweep after reset; 0: enter RUN immediately
// PORTS
//  clk               in   1       clock; all state updates on the rising edge
//  rst               in   1       reset, asynchronous, active-high
//  req0_valid        in   1       requester 0 has a write pending
//  req0_reg          in   ADDR_W  requester 0 destination register
//  req0_data         in   DATA_W  requester 0 write data
//  req0_ready        out  1       requester 0 write accepted this cycle (combinational)
//  req1_valid        in   1       requester 1 has a write pending
//  req1_reg          in   ADDR_W  requester 1 destination register
//  req1_data         in   DATA_W  requester 1 write data
//  req1_ready        out  1       requester 1 write accepted this cycle (combinational)
//  write_reg         out  ADDR_W  to mips_registers write_reg (registered)
//  write_data        out  DATA_W  to mips_registers write_data (registered)
//  signal_reg_write  out  1       to mips_registers signal_reg_write (registered)
//  init_done         out  1       high once the sweep completes; stays high until rst
// BEHAVIOUR
//  Reset values
//   - rst high (async) -> signal_reg_write=0, write_reg=0, write_data=0, clr_idx=0, rr_ptr=0.
//   - state=CLEAR and init_done=0 when CLEAR_ON_RESET=1.
//   - state=RUN and init_done=1 when CLEAR_ON_RESET=0.
//   - rst asserted mid-sweep or mid-run: all in-flight state is abandoned; the sweep restarts at index 0.
//  FSM CLEAR
//   - Each cycle registers {write_reg=clr_idx, write_data=0, signal_reg_write=1}.
//   - clr_idx increments each cycle.
//   - When clr_idx==NREGS-1 the state goes to RUN and init_done=1 on the same edge.
//   - Sweep length is exactly NREGS cycles.
//   - Both readies are held at 0 throughout CLEAR.
//  FSM RUN
//   - Grant is combinational from the valids and rr_ptr.
//   - Only one valid: that requester is granted.
//   - Both valid: requester rr_ptr is granted.
//   - reqN_ready = grantN. A transfer happens when valid & ready.
//   - A granted requester holds its reg/data stable only while valid & !ready.
//   - On a transfer the next edge registers write_reg=req_reg and write_data=req_data.
//   - signal_reg_write = (req_reg != 0). Writes to $zero are acknowledged but suppressed.
//   - No transfer -> signal_reg_write=0 next cycle; write_reg/write_data hold.
//   - rr_ptr <= ~granted index after every transfer, so the loser of a tie wins the next tie.
//   - Latency: the write is presented to the register file 1 cycle after acceptance. Throughput is 1 write/cycle.
//   - Both requesters targeting the same register in the same cycle: arbitrated normally, no merging. Final value = whichever is granted second.
//   - No FSM exit from RUN except rst.
//  Width rules
//   - clr_idx is ADDR_W bits.
//   - The terminal compare uses NREGS-1, so no wrap occurs when NREGS==2**ADDR_W.
// STRUCTURE
//  - Shared package mips_pkg holds ADDR_W/DATA_W defaults, the arbiter state encoding (CLEAR=1'b0, RUN=1'b1) and REG_ZERO=5'd0.
//  - Sub-module mips_rr_arb2 is the 2-way round-robin grant logic: valid[1:0], rr_ptr -> grant[1:0].
//  - The parent holds the FSM, clr_idx, rr_ptr and the output registers.
// TESTING
//  1. Release rst, no requests -> signal_reg_write=1 for 32 cycles, write_reg 0..31, write_data=0. init_done rises with the 32nd edge. Reading all regs gives 0.
//  2. After init, req0 only, reg=5, data=0xDEADBEEF -> req0_ready=1 same cycle. Next cycle write_reg=5, write_data=0xDEADBEEF, sig=1. Reg 5 reads back 0xDEADBEEF.
//  3. Both valid for 4 cycles (req0 reg=3, req1 reg=4, data incrementing) -> grants alternate 0,1,0,1. Exactly one ready per cycle; 4 writes issued.
//  4. req1 writes reg=0, data=0x1234 -> req1_ready=1, next-cycle sig=0, reg 0 still reads 0.
//  5. Request during CLEAR (req0 valid at cycle 10) -> ready=0 until init_done. Accepted the first RUN cycle.
//  6. Assert rst at sweep cycle 15, release -> outputs zero asynchronously, init_done=0, sweep restarts at write_reg=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the mips_registers write-port arbiter.
//   ADDR_W_DEF / DATA_W_DEF / NREGS_DEF : default register-file geometry
//   arb_state_e                         : arbiter FSM encoding
//   REG_ZERO                            : index of the hard-wired $zero register
package mips_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NREGS_DEF  = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/mips_rr_arb2.sv
// Two-way round-robin grant logic.
//   valid_i[1:0] : pending requests
//   rr_ptr_i     : requester that wins when both are valid
//   grant_c_o    : one-hot (or zero) grant, combinational
module mips_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       rr_ptr_i,
    output logic [1:0] grant_c_o
);

    // A lone requester always wins; a tie goes to the pointed-at requester.
    always_comb begin
        grant_c_o    = 2'b00;
        grant_c_o[0] = valid_i[0] & (~valid_i[1] | ~rr_ptr_i);
        grant_c_o[1] = valid_i[1] & (~valid_i[0] |  rr_ptr_i);
    end

endmodule : mips_rr_arb2

// File: rtl/mips_regfile_write_arbiter.sv
// Single owner of the mips_registers write port.
// After reset it zero-fills every register, then shares the port between
// requester 0 (ALU writeback) and requester 1 (load return) round-robin.
//   clk, rst                       : clock, async active-high reset
//   req{0,1}_valid/_reg/_data      : write requests
//   req{0,1}_ready                 : combinational accept (valid & ready = transfer)
//   write_reg/write_data           : registered register-file write address/data
//   signal_reg_write               : registered write enable ($zero writes suppressed)
//   init_done                      : sticky high once the clear sweep has finished
module mips_regfile_write_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned NREGS          = NREGS_DEF,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              signal_reg_write,
    output logic              init_done
);

    // Terminal compare against NREGS-1 keeps the sweep exact even when NREGS fills ADDR_W.
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX    = ADDR_W'(REG_ZERO);
    localparam arb_state_e        RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              sig_q, sig_d;
    logic              init_done_q, init_done_d;
    logic [1:0]        grant;

    mips_rr_arb2 u_arb (
        .valid_i   ({req1_valid, req0_valid}),
        .rr_ptr_i  (rr_ptr_q),
        .grant_c_o (grant)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            clr_idx_q    <= '0;
            rr_ptr_q     <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            sig_q        <= 1'b0;
            init_done_q  <= ~CLEAR_ON_RESET;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            sig_q        <= sig_d;
            init_done_q  <= init_done_d;
        end
    end

    // Next-state, next-write and accept logic.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        rr_ptr_d     = rr_ptr_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        sig_d        = 1'b0;
        init_done_d  = init_done_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            CLEAR: begin
                write_reg_d  = clr_idx_q;
                write_data_d = '0;
                sig_d        = 1'b1;
                clr_idx_d    = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (grant[0]) begin
                    write_reg_d  = req0_reg;
                    write_data_d = req0_data;
                    sig_d        = (req0_reg != ZERO_IDX);
                    rr_ptr_d     = 1'b1;
                end else if (grant[1]) begin
                    write_reg_d  = req1_reg;
                    write_data_d = req1_data;
                    sig_d        = (req1_reg != ZERO_IDX);
                    rr_ptr_d     = 1'b0;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign write_reg        = write_reg_q;
    assign write_data       = write_data_q;
    assign signal_reg_write = sig_q;
    assign init_done        = init_done_q;

endmodule : mips_regfile_write_arbiter

// File: tb/tb_mips_regfile_write_arbiter.sv
module tb_mips_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_reg, req1_reg;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        signal_reg_write;
    logic        init_done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_regfile_write_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid       (req0_valid),
        .req0_reg         (req0_reg),
        .req0_data        (req0_data),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_reg         (req1_reg),
        .req1_data        (req1_data),
        .req1_ready       (req1_ready),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .signal_reg_write (signal_reg_write),
        .init_done        (init_done)
    );

    // Reference model: what the register-file port should show, from the rules.
    bit          m_clear;
    int          m_swept;      // registers cleared so far
    int          m_tie;        // requester that wins the next tie
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        m_sig;
    logic        m_init;
    logic [31:0] m_rf [32];    // expected register-file contents
    logic [31:0] shadow [32];  // register file fed by the DUT's write port

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clear = 1'b1;
        m_swept = 0;
        m_tie   = 0;
        m_reg   = '0;
        m_data  = '0;
        m_sig   = 1'b0;
        m_init  = 1'b0;
    endtask

    function automatic int model_winner(input logic v0, input logic v1);
        if (m_clear)   return -1;
        if (v0 && v1)  return m_tie;
        if (v0)        return 0;
        if (v1)        return 1;
        return -1;
    endfunction

    task automatic check_outputs();
        check("write_reg",  32'(write_reg),        32'(m_reg));
        check("write_data", write_data,            m_data);
        check("sig",        32'(signal_reg_write), 32'(m_sig));
        check("init_done",  32'(init_done),        32'(m_init));
    endtask

    // One clock cycle; entered and left at a falling edge.
    task automatic cycle(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                         output logic rd0, output logic rd1);
        int w;
        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
        #1;
        w = model_winner(v0, v1);
        check("req0_ready", 32'(req0_ready), 32'(w == 0));
        check("req1_ready", 32'(req1_ready), 32'(w == 1));
        rd0 = req0_ready;
        rd1 = req1_ready;
        @(posedge clk);
        if (m_clear) begin
            m_reg  = 5'(m_swept);
            m_data = '0;
            m_sig  = 1'b1;
            m_rf[m_swept] = '0;
            m_swept++;
            if (m_swept == 32) begin
                m_clear = 1'b0;
                m_init  = 1'b1;
            end
        end else if (w >= 0) begin
            m_reg  = (w == 0) ? r0 : r1;
            m_data = (w == 0) ? d0 : d1;
            m_sig  = (m_reg != 5'd0);
            if (m_sig) m_rf[m_reg] = m_data;
            m_tie  = 1 - w;
        end else begin
            m_sig = 1'b0;
        end
        #1;
        check_outputs();
        if (signal_reg_write) shadow[write_reg] = write_data;
        @(negedge clk);
    endtask

    // Reset pulse; entered and left at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic v0; logic [4:0] r0; logic [31:0] d0;
        logic v1; logic [4:0] r1; logic [31:0] d1;
        logic rdy0; logic rdy1; logic sig; logic [4:0] wreg; logic [31:0] wdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rd0, rd1;
        logic p0_v, p1_v;
        logic [4:0] p0_r, p1_r;
        logic [31:0] p0_d, p1_d;

        // Post-init directed vectors: lone write, alternating ties, $zero write, idle.
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,   1'b0, 1'b1, 1'b1, 5'd7, 32'h77};
        vecs[2] = '{1'b1, 5'd3, 32'h10,       1'b1, 5'd4, 32'h20,   1'b1, 1'b0, 1'b1, 5'd3, 32'h10};
        vecs[3] = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h20,   1'b0, 1'b1, 1'b1, 5'd4, 32'h20};
        vecs[4] = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h21,   1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
        vecs[5] = '{1'b1, 5'd3, 32'h12,       1'b1, 5'd4, 32'h21,   1'b0, 1'b1, 1'b1, 5'd4, 32'h21};
        vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 5'd0, 32'h1234};

        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 32'hBAD0_0000 + 32'(i);
            shadow[i] = 32'hBAD0_0000 + 32'(i);
        end
        rst = 1'b1;
        req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
        req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
        @(negedge clk);
        do_reset();

        // Plain sweep: write_reg walks 0..31 with zero data, init_done on the last edge.
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rd0, rd1);
            check("sweep_idx",  32'(write_reg),  32'(i));
            check("sweep_init", 32'(init_done),  32'(i == 31));
        end
        for (int i = 0; i < 32; i++) check("cleared_reg", shadow[i], 32'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].v0, vecs[i].r0, vecs[i].d0, vecs[i].v1, vecs[i].r1, vecs[i].d1, rd0, rd1);
            check("tbl_rdy0",  32'(rd0),              32'(vecs[i].rdy0));
            check("tbl_rdy1",  32'(rd1),              32'(vecs[i].rdy1));
            check("tbl_sig",   32'(signal_reg_write), 32'(vecs[i].sig));
            check("tbl_wreg",  32'(write_reg),        32'(vecs[i].wreg));
            check("tbl_wdata", write_data,            vecs[i].wdata);
        end
        check("rb_r5", shadow[5], 32'hDEADBEEF);
        check("rb_r3", shadow[3], 32'h11);
        check("rb_r4", shadow[4], 32'h21);
        check("rb_r0", shadow[0], 32'h0);

        // Reset in the middle of a sweep, then a request waiting through CLEAR.
        do_reset();
        for (int i = 0; i < 15; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rd0, rd1);
        rst = 1'b1;
        #1;
        check("async_wreg", 32'(write_reg),        32'd0);
        check("async_sig",  32'(signal_reg_write), 32'd0);
        check("async_init", 32'(init_done),        32'd0);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 32; i++) begin
            cycle(i >= 10, 5'd9, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, rd0, rd1);
            if (i == 0) check("restart_idx", 32'(write_reg), 32'd0);
            if (i >= 10) check("clear_hold_rdy0", 32'(rd0), 32'd0);
        end
        cycle(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, rd0, rd1);
        check("first_run_accept", 32'(rd0), 32'd1);
        check("first_run_wreg",   32'(write_reg), 32'd9);

        // Randomized traffic with the hold-until-accepted rule.
        p0_v = 1'b0; p1_v = 1'b0; p0_r = '0; p1_r = '0; p0_d = '0; p1_d = '0;
        rd0 = 1'b0; rd1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0_v || rd0) begin
                p0_v = ($urandom_range(0, 3) != 0);
                p0_r = 5'($urandom_range(0, 31));
                p0_d = $urandom;
            end
            if (!p1_v || rd1) begin
                p1_v = ($urandom_range(0, 3) != 0);
                p1_r = ($urandom_range(0, 7) == 0) ? p0_r : 5'($urandom_range(0, 31));
                p1_d = $urandom;
            end
            cycle(p0_v, p0_r, p0_d, p1_v, p1_r, p1_d, rd0, rd1);
        end
        for (int i = 0; i < 32; i++) check("rand_readback", shadow[i], m_rf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mips_regfile_write_arbiter
